// File: rtl/magicore_axi_pkg.sv
// Shared AXI4 encodings, FSM state types and response folding for the burst splitter.
package magicore_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_BRESP} wr_state_t;

    // Worst-of two responses; EXOKAY carries no meaning for a split burst so it folds to OKAY.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] fa;
        logic [1:0] fb;
        fa = (a == RESP_EXOKAY) ? RESP_OKAY : a;
        fb = (b == RESP_EXOKAY) ? RESP_OKAY : b;
        return (fa > fb) ? fa : fb;
    endfunction

endpackage

// File: rtl/axi4_split_addr_gen.sv
// Next-beat address and legality check for one burst path (INCR/FIXED only).
module axi4_split_addr_gen
    import magicore_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STRB_W = 4
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic              o_legal
);

    localparam int SIZE_MAX = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    assign o_legal = ((i_burst == BURST_INCR) || (i_burst == BURST_FIXED)) &&
                     (int'(i_size) <= SIZE_MAX);

    // Plain ADDR_W-bit addition gives the modulo-2^ADDR_W wrap for free.
    assign o_next_addr = (i_burst == BURST_INCR) ? (i_addr + (ONE << i_size)) : i_addr;

endmodule

// File: rtl/axi4_burst_splitter.sv
// AXI4 burst-to-single-beat adapter: independent read and write FSMs, one beat outstanding per path.
module axi4_burst_splitter
    import magicore_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 16,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_aw_valid,
    output logic              s_aw_ready,
    input  logic [ADDR_W-1:0] s_aw_addr,
    input  logic [ID_W-1:0]   s_aw_id,
    input  logic [7:0]        s_aw_len,
    input  logic [2:0]        s_aw_size,
    input  logic [1:0]        s_aw_burst,
    input  logic              s_w_valid,
    output logic              s_w_ready,
    input  logic [DATA_W-1:0] s_w_data,
    input  logic [STRB_W-1:0] s_w_strb,
    input  logic              s_w_last,
    output logic              s_b_valid,
    input  logic              s_b_ready,
    output logic [ID_W-1:0]   s_b_id,
    output logic [1:0]        s_b_resp,
    input  logic              s_ar_valid,
    output logic              s_ar_ready,
    input  logic [ADDR_W-1:0] s_ar_addr,
    input  logic [ID_W-1:0]   s_ar_id,
    input  logic [7:0]        s_ar_len,
    input  logic [2:0]        s_ar_size,
    input  logic [1:0]        s_ar_burst,
    output logic              s_r_valid,
    input  logic              s_r_ready,
    output logic [DATA_W-1:0] s_r_data,
    output logic [ID_W-1:0]   s_r_id,
    output logic [1:0]        s_r_resp,
    output logic              s_r_last,
    output logic              m_aw_valid,
    input  logic              m_aw_ready,
    output logic [ADDR_W-1:0] m_aw_addr,
    output logic [ID_W-1:0]   m_aw_id,
    output logic [7:0]        m_aw_len,
    output logic [2:0]        m_aw_size,
    output logic [1:0]        m_aw_burst,
    output logic              m_w_valid,
    input  logic              m_w_ready,
    output logic [DATA_W-1:0] m_w_data,
    output logic [STRB_W-1:0] m_w_strb,
    output logic              m_w_last,
    input  logic              m_b_valid,
    output logic              m_b_ready,
    input  logic [ID_W-1:0]   m_b_id,
    input  logic [1:0]        m_b_resp,
    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    output logic [ADDR_W-1:0] m_ar_addr,
    output logic [ID_W-1:0]   m_ar_id,
    output logic [7:0]        m_ar_len,
    output logic [2:0]        m_ar_size,
    output logic [1:0]        m_ar_burst,
    input  logic              m_r_valid,
    output logic              m_r_ready,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic [ID_W-1:0]   m_r_id,
    input  logic [1:0]        m_r_resp,
    input  logic              m_r_last,
    output logic              err_proto,
    output rd_state_t         o_dbg_rd_state,
    output wr_state_t         o_dbg_wr_state
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
    // every valid we drive holds its payload until accepted.

    rd_state_t         r_rd_state;
    logic              r_s_ar_ready, r_m_ar_valid, r_rd_err;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ID_W-1:0]   r_rd_id;
    logic [7:0]        r_rd_len, r_rd_beat;
    logic [2:0]        r_rd_size;
    logic [1:0]        r_rd_burst;

    wr_state_t         r_wr_state;
    logic              r_s_aw_ready, r_m_aw_valid, r_m_b_ready, r_s_b_valid;
    logic              r_wr_err, r_aw_sent, r_w_sent, r_err_proto;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ID_W-1:0]   r_wr_id;
    logic [7:0]        r_wr_len, r_wr_beat;
    logic [2:0]        r_wr_size;
    logic [1:0]        r_wr_burst, r_acc_resp;

    logic [ADDR_W-1:0] w_rd_next, w_wr_next;
    logic              w_rd_legal, w_wr_legal;
    logic [2:0]        w_rd_size, w_wr_size;
    logic [1:0]        w_rd_burst, w_wr_burst;
    logic              w_rd_last, w_s_r_valid, w_r_hs;
    logic              w_wr_last, w_w_open, w_s_w_ready, w_w_hs, w_aw_hs, w_b_done;
    logic [1:0]        w_b_resp_in;
    logic              w_unused;

    // While idle the checker sees the incoming request so legality is known at accept time.
    assign w_rd_size  = (r_rd_state == R_IDLE) ? s_ar_size  : r_rd_size;
    assign w_rd_burst = (r_rd_state == R_IDLE) ? s_ar_burst : r_rd_burst;
    assign w_wr_size  = (r_wr_state == W_IDLE) ? s_aw_size  : r_wr_size;
    assign w_wr_burst = (r_wr_state == W_IDLE) ? s_aw_burst : r_wr_burst;

    axi4_split_addr_gen #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_rd_gen (
        .i_addr(r_rd_addr), .i_size(w_rd_size), .i_burst(w_rd_burst),
        .o_next_addr(w_rd_next), .o_legal(w_rd_legal)
    );

    axi4_split_addr_gen #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_wr_gen (
        .i_addr(r_wr_addr), .i_size(w_wr_size), .i_burst(w_wr_burst),
        .o_next_addr(w_wr_next), .o_legal(w_wr_legal)
    );

    assign w_rd_last   = (r_rd_beat == r_rd_len);
    assign w_s_r_valid = (r_rd_state == R_DATA) && (r_rd_err || m_r_valid);
    assign w_r_hs      = w_s_r_valid && s_r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state   <= R_IDLE;
            r_s_ar_ready <= 1'b0;
            r_m_ar_valid <= 1'b0;
            r_rd_err     <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_id      <= '0;
            r_rd_len     <= '0;
            r_rd_beat    <= '0;
            r_rd_size    <= '0;
            r_rd_burst   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    r_s_ar_ready <= 1'b1;
                    if (r_s_ar_ready && s_ar_valid) begin
                        r_rd_addr    <= s_ar_addr;
                        r_rd_id      <= s_ar_id;
                        r_rd_len     <= s_ar_len;
                        r_rd_size    <= s_ar_size;
                        r_rd_burst   <= s_ar_burst;
                        r_rd_beat    <= '0;
                        r_rd_err     <= !w_rd_legal;
                        r_s_ar_ready <= 1'b0;
                        r_m_ar_valid <= w_rd_legal;
                        r_rd_state   <= w_rd_legal ? R_ADDR : R_DATA;
                    end
                end
                R_ADDR: begin
                    if (m_ar_ready) begin
                        r_m_ar_valid <= 1'b0;
                        r_rd_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (w_rd_last) begin
                            r_rd_state <= R_IDLE;
                        end else begin
                            r_rd_beat <= r_rd_beat + 8'd1;
                            r_rd_addr <= w_rd_next;
                            if (!r_rd_err) begin
                                r_rd_state   <= R_ADDR;
                                r_m_ar_valid <= 1'b1;
                            end
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign w_wr_last   = (r_wr_beat == r_wr_len);
    assign w_w_open    = (r_wr_state == W_XFER) && !r_w_sent;
    assign w_s_w_ready = w_w_open && (r_wr_err || m_w_ready);
    assign w_w_hs      = w_s_w_ready && s_w_valid;
    assign w_aw_hs     = r_m_aw_valid && m_aw_ready;
    assign w_b_done    = (r_wr_state == W_RESP) && (r_wr_err || (r_m_b_ready && m_b_valid));
    assign w_b_resp_in = r_wr_err ? RESP_SLVERR : m_b_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state   <= W_IDLE;
            r_s_aw_ready <= 1'b0;
            r_m_aw_valid <= 1'b0;
            r_m_b_ready  <= 1'b0;
            r_s_b_valid  <= 1'b0;
            r_wr_err     <= 1'b0;
            r_aw_sent    <= 1'b0;
            r_w_sent     <= 1'b0;
            r_err_proto  <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_id      <= '0;
            r_wr_len     <= '0;
            r_wr_beat    <= '0;
            r_wr_size    <= '0;
            r_wr_burst   <= '0;
            r_acc_resp   <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    r_s_aw_ready <= 1'b1;
                    if (r_s_aw_ready && s_aw_valid) begin
                        r_wr_addr    <= s_aw_addr;
                        r_wr_id      <= s_aw_id;
                        r_wr_len     <= s_aw_len;
                        r_wr_size    <= s_aw_size;
                        r_wr_burst   <= s_aw_burst;
                        r_wr_beat    <= '0;
                        r_acc_resp   <= RESP_OKAY;
                        r_wr_err     <= !w_wr_legal;
                        r_aw_sent    <= !w_wr_legal;
                        r_w_sent     <= 1'b0;
                        r_m_aw_valid <= w_wr_legal;
                        r_s_aw_ready <= 1'b0;
                        r_wr_state   <= W_XFER;
                    end
                end
                W_XFER: begin
                    if (w_aw_hs) begin
                        r_m_aw_valid <= 1'b0;
                        r_aw_sent    <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_sent <= 1'b1;
                        if (s_w_last != w_wr_last) begin
                            r_err_proto <= 1'b1;
                            r_acc_resp  <= RESP_SLVERR;
                        end
                    end
                    if ((r_aw_sent || w_aw_hs) && (r_w_sent || w_w_hs)) begin
                        r_wr_state  <= W_RESP;
                        r_m_b_ready <= !r_wr_err;
                    end
                end
                W_RESP: begin
                    if (w_b_done) begin
                        r_m_b_ready <= 1'b0;
                        r_acc_resp  <= resp_max(r_acc_resp, w_b_resp_in);
                        if (w_wr_last) begin
                            r_s_b_valid <= 1'b1;
                            r_wr_state  <= W_BRESP;
                        end else begin
                            r_wr_beat    <= r_wr_beat + 8'd1;
                            r_wr_addr    <= w_wr_next;
                            r_aw_sent    <= r_wr_err;
                            r_w_sent     <= 1'b0;
                            r_m_aw_valid <= !r_wr_err;
                            r_wr_state   <= W_XFER;
                        end
                    end
                end
                W_BRESP: begin
                    if (s_b_ready) begin
                        r_s_b_valid <= 1'b0;
                        r_wr_state  <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign s_ar_ready = r_s_ar_ready;
    assign m_ar_valid = r_m_ar_valid;
    assign m_ar_addr  = r_rd_addr;
    assign m_ar_id    = r_rd_id;
    assign m_ar_len   = 8'd0;
    assign m_ar_size  = r_rd_size;
    assign m_ar_burst = BURST_INCR;
    assign m_r_ready  = (r_rd_state == R_DATA) && !r_rd_err && s_r_ready;
    assign s_r_valid  = w_s_r_valid;
    assign s_r_data   = r_rd_err ? '0 : m_r_data;
    assign s_r_resp   = r_rd_err ? RESP_SLVERR : m_r_resp;
    assign s_r_id     = r_rd_id;
    assign s_r_last   = w_rd_last;

    assign s_aw_ready = r_s_aw_ready;
    assign m_aw_valid = r_m_aw_valid;
    assign m_aw_addr  = r_wr_addr;
    assign m_aw_id    = r_wr_id;
    assign m_aw_len   = 8'd0;
    assign m_aw_size  = r_wr_size;
    assign m_aw_burst = BURST_INCR;
    assign s_w_ready  = w_s_w_ready;
    assign m_w_valid  = w_w_open && !r_wr_err && s_w_valid;
    assign m_w_data   = s_w_data;
    assign m_w_strb   = s_w_strb;
    assign m_w_last   = 1'b1;
    assign m_b_ready  = r_m_b_ready;
    assign s_b_valid  = r_s_b_valid;
    assign s_b_id     = r_wr_id;
    assign s_b_resp   = r_acc_resp;
    assign err_proto  = r_err_proto;

    assign o_dbg_rd_state = r_rd_state;
    assign o_dbg_wr_state = r_wr_state;

    // Downstream ids and R last are not trusted; the latched burst state is authoritative.
    assign w_unused = &{1'b0, m_b_id, m_r_id, m_r_last};

endmodule

// File: tb/tb_axi4_burst_splitter.sv
// Directed bench for axi4_burst_splitter: hand-computed vectors on both paths, error bursts and reset.
module tb_axi4_burst_splitter;
    import magicore_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_aw_valid, s_aw_ready;
    logic [31:0] s_aw_addr;
    logic [15:0] s_aw_id;
    logic [7:0]  s_aw_len;
    logic [2:0]  s_aw_size;
    logic [1:0]  s_aw_burst;
    logic        s_w_valid, s_w_ready, s_w_last;
    logic [31:0] s_w_data;
    logic [3:0]  s_w_strb;
    logic        s_b_valid, s_b_ready;
    logic [15:0] s_b_id;
    logic [1:0]  s_b_resp;
    logic        s_ar_valid, s_ar_ready;
    logic [31:0] s_ar_addr;
    logic [15:0] s_ar_id;
    logic [7:0]  s_ar_len;
    logic [2:0]  s_ar_size;
    logic [1:0]  s_ar_burst;
    logic        s_r_valid, s_r_ready, s_r_last;
    logic [31:0] s_r_data;
    logic [15:0] s_r_id;
    logic [1:0]  s_r_resp;
    logic        m_aw_valid, m_aw_ready;
    logic [31:0] m_aw_addr;
    logic [15:0] m_aw_id;
    logic [7:0]  m_aw_len;
    logic [2:0]  m_aw_size;
    logic [1:0]  m_aw_burst;
    logic        m_w_valid, m_w_ready, m_w_last;
    logic [31:0] m_w_data;
    logic [3:0]  m_w_strb;
    logic        m_b_valid, m_b_ready;
    logic [15:0] m_b_id;
    logic [1:0]  m_b_resp;
    logic        m_ar_valid, m_ar_ready;
    logic [31:0] m_ar_addr;
    logic [15:0] m_ar_id;
    logic [7:0]  m_ar_len;
    logic [2:0]  m_ar_size;
    logic [1:0]  m_ar_burst;
    logic        m_r_valid, m_r_ready, m_r_last;
    logic [31:0] m_r_data;
    logic [15:0] m_r_id;
    logic [1:0]  m_r_resp;
    logic        err_proto;
    rd_state_t   dbg_rd_state;
    wr_state_t   dbg_wr_state;

    int n_vec = 0;
    int n_bad = 0;

    axi4_burst_splitter #(.ADDR_W(32), .DATA_W(32), .ID_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
        .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_w_last(s_w_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
        .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id),
        .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
        .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_w_last(m_w_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
        .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_id(m_r_id),
        .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .err_proto(err_proto), .o_dbg_rd_state(dbg_rd_state), .o_dbg_wr_state(dbg_wr_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        s_ar_valid = 1'b1; s_ar_addr = addr; s_ar_id = id;
        s_ar_len = len; s_ar_size = size; s_ar_burst = burst;
        #1;
        while (!s_ar_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("s_ar_ready", s_ar_ready, 1);
        @(posedge clk); #1;
        s_ar_valid = 1'b0;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        s_aw_valid = 1'b1; s_aw_addr = addr; s_aw_id = id;
        s_aw_len = len; s_aw_size = size; s_aw_burst = burst;
        #1;
        while (!s_aw_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("s_aw_ready", s_aw_ready, 1);
        @(posedge clk); #1;
        s_aw_valid = 1'b0;
    endtask

    // One split read beat: downstream AR handshake, then R pass-through to the master.
    task automatic rd_beat(input logic [31:0] exp_addr, input logic [31:0] rdata, input logic exp_last,
                           input logic [15:0] exp_id, input logic [1:0] rresp);
        int n = 0;
        while (!m_ar_valid && n < 20) begin @(negedge clk); #1; n++; end
        check("m_ar_valid", m_ar_valid, 1);
        check("m_ar_addr", m_ar_addr, exp_addr);
        check("m_ar_len", m_ar_len, 0);
        check("m_ar_id", m_ar_id, exp_id);
        check("m_ar_burst", m_ar_burst, 2'b01);
        m_ar_ready = 1'b1;
        @(posedge clk); #1;
        m_ar_ready = 1'b0;
        check("m_ar_drop", m_ar_valid, 0);
        m_r_valid = 1'b1; m_r_data = rdata; m_r_resp = rresp; m_r_id = 16'hDEAD; m_r_last = 1'b0;
        s_r_ready = 1'b1;
        #1;
        check("s_r_valid", s_r_valid, 1);
        check("m_r_ready", m_r_ready, 1);
        check("s_r_data", s_r_data, rdata);
        check("s_r_resp", s_r_resp, rresp);
        check("s_r_id", s_r_id, exp_id);
        check("s_r_last", s_r_last, exp_last);
        @(posedge clk); #1;
        m_r_valid = 1'b0; s_r_ready = 1'b0;
    endtask

    task automatic rd_err_beat(input logic exp_last, input logic [15:0] exp_id);
        s_r_ready = 1'b1;
        #1;
        check("err_m_ar_valid", m_ar_valid, 0);
        check("err_m_r_ready", m_r_ready, 0);
        check("err_s_r_valid", s_r_valid, 1);
        check("err_s_r_resp", s_r_resp, 2'b10);
        check("err_s_r_data", s_r_data, 0);
        check("err_s_r_last", s_r_last, exp_last);
        check("err_s_r_id", s_r_id, exp_id);
        @(posedge clk); #1;
        s_r_ready = 1'b0;
    endtask

    // One split write beat: AW and W together downstream, then one B with the given response.
    task automatic wr_beat(input logic [31:0] exp_addr, input logic [31:0] wdata, input logic wlast,
                           input logic [1:0] bresp);
        int n = 0;
        while (!m_aw_valid && n < 20) begin @(negedge clk); #1; n++; end
        s_w_valid = 1'b1; s_w_data = wdata; s_w_strb = 4'hA; s_w_last = wlast;
        m_aw_ready = 1'b1; m_w_ready = 1'b1;
        #1;
        check("m_aw_valid", m_aw_valid, 1);
        check("m_aw_addr", m_aw_addr, exp_addr);
        check("m_aw_len", m_aw_len, 0);
        check("m_aw_burst", m_aw_burst, 2'b01);
        check("m_w_valid", m_w_valid, 1);
        check("m_w_data", m_w_data, wdata);
        check("m_w_strb", m_w_strb, 4'hA);
        check("m_w_last", m_w_last, 1);
        check("s_w_ready", s_w_ready, 1);
        @(posedge clk); #1;
        s_w_valid = 1'b0; m_aw_ready = 1'b0; m_w_ready = 1'b0;
        m_b_valid = 1'b1; m_b_resp = bresp; m_b_id = 16'hBEEF;
        #1;
        check("m_b_ready", m_b_ready, 1);
        @(posedge clk); #1;
        m_b_valid = 1'b0;
    endtask

    task automatic wr_err_beat(input logic wlast);
        s_w_valid = 1'b1; s_w_data = 32'h5555_AAAA; s_w_strb = 4'hF; s_w_last = wlast;
        #1;
        check("err_m_aw_valid", m_aw_valid, 0);
        check("err_m_w_valid", m_w_valid, 0);
        check("err_s_w_ready", s_w_ready, 1);
        @(posedge clk); #1;
        s_w_valid = 1'b0;
    endtask

    task automatic b_expect(input logic [15:0] exp_id, input logic [1:0] exp_resp);
        int n = 0;
        s_b_ready = 1'b1;
        #1;
        while (!s_b_valid && n < 20) begin @(negedge clk); #1; n++; end
        check("s_b_valid", s_b_valid, 1);
        check("s_b_id", s_b_id, exp_id);
        check("s_b_resp", s_b_resp, exp_resp);
        @(posedge clk); #1;
        s_b_ready = 1'b0;
        check("s_b_drop", s_b_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        s_aw_valid = 0; s_aw_addr = 0; s_aw_id = 0; s_aw_len = 0; s_aw_size = 0; s_aw_burst = 0;
        s_w_valid = 0; s_w_data = 0; s_w_strb = 0; s_w_last = 0; s_b_ready = 0;
        s_ar_valid = 0; s_ar_addr = 0; s_ar_id = 0; s_ar_len = 0; s_ar_size = 0; s_ar_burst = 0;
        s_r_ready = 0; m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_id = 0; m_b_resp = 0;
        m_ar_ready = 0; m_r_valid = 0; m_r_data = 0; m_r_id = 0; m_r_resp = 0; m_r_last = 0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_s_ar_ready", s_ar_ready, 0);
        check("rst_s_aw_ready", s_aw_ready, 0);
        check("rst_m_ar_valid", m_ar_valid, 0);
        check("rst_m_aw_valid", m_aw_valid, 0);
        check("rst_s_b_valid", s_b_valid, 0);
        check("rst_err_proto", err_proto, 0);
        check("rst_rd_state", dbg_rd_state, R_IDLE);
        check("rst_wr_state", dbg_wr_state, W_IDLE);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        s_w_valid = 1'b1;
        #1;
        check("idle_s_ar_ready", s_ar_ready, 1);
        check("w_before_aw", s_w_ready, 0);
        check("w_before_aw_m", m_w_valid, 0);
        s_w_valid = 1'b0;

        // INCR read, 4 beats of 4 bytes
        ar_send(32'h0000_1000, 16'h0005, 8'd3, 3'd2, BURST_INCR);
        check("ar_latency", m_ar_valid, 1);
        for (int i = 0; i < 4; i++)
            rd_beat(32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), (i == 3), 16'h0005, RESP_OKAY);
        check("rd_back_idle", dbg_rd_state, R_IDLE);

        // Address wraps at 2^32; R resp passes straight through
        ar_send(32'hFFFF_FFFC, 16'h0007, 8'd1, 3'd2, BURST_INCR);
        rd_beat(32'hFFFF_FFFC, 32'h1111_1111, 1'b0, 16'h0007, RESP_OKAY);
        rd_beat(32'h0000_0000, 32'h2222_2222, 1'b1, 16'h0007, RESP_DECERR);

        // WRAP read is answered locally with SLVERR
        ar_send(32'h0000_3000, 16'h0009, 8'd1, 3'd2, BURST_WRAP);
        rd_err_beat(1'b0, 16'h0009);
        rd_err_beat(1'b1, 16'h0009);
        check("wrap_no_ar", m_ar_valid, 0);

        // FIXED write, responses fold to the worst
        aw_send(32'h0000_2000, 16'h0021, 8'd1, 3'd2, BURST_FIXED);
        wr_beat(32'h0000_2000, 32'hCAFE_0001, 1'b0, RESP_OKAY);
        wr_beat(32'h0000_2000, 32'hCAFE_0002, 1'b1, RESP_SLVERR);
        b_expect(16'h0021, RESP_SLVERR);
        check("fixed_err_proto", err_proto, 0);

        // EXOKAY from a single-beat write reports OKAY upstream
        aw_send(32'h0000_2100, 16'h0022, 8'd0, 3'd2, BURST_INCR);
        wr_beat(32'h0000_2100, 32'h0BAD_F00D, 1'b1, RESP_EXOKAY);
        b_expect(16'h0022, RESP_OKAY);

        // W last asserted early: full len still transferred, sticky error, SLVERR
        aw_send(32'h0000_4000, 16'h0033, 8'd2, 3'd2, BURST_INCR);
        wr_beat(32'h0000_4000, 32'h0000_0040, 1'b0, RESP_OKAY);
        wr_beat(32'h0000_4004, 32'h0000_0041, 1'b1, RESP_OKAY);
        wr_beat(32'h0000_4008, 32'h0000_0042, 1'b0, RESP_OKAY);
        b_expect(16'h0033, RESP_SLVERR);
        check("last_err_proto", err_proto, 1);

        // Oversized write beat is consumed without downstream access
        aw_send(32'h0000_5000, 16'h0044, 8'd0, 3'd3, BURST_INCR);
        wr_err_beat(1'b1);
        b_expect(16'h0044, RESP_SLVERR);

        // Reset in the middle of a read data phase
        ar_send(32'h0000_6000, 16'h0066, 8'd1, 3'd2, BURST_INCR);
        m_ar_ready = 1'b1;
        @(posedge clk); #1;
        m_ar_ready = 1'b0;
        m_r_valid = 1'b1; m_r_data = 32'h6666_6666; m_r_resp = RESP_OKAY;
        #1;
        check("pre_rst_s_r_valid", s_r_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_s_r_valid", s_r_valid, 0);
        check("mid_rst_m_r_ready", m_r_ready, 0);
        check("mid_rst_m_ar_valid", m_ar_valid, 0);
        check("mid_rst_s_ar_ready", s_ar_ready, 0);
        check("mid_rst_err_proto", err_proto, 0);
        check("mid_rst_rd_state", dbg_rd_state, R_IDLE);
        @(negedge clk);
        rst = 1'b0;
        m_r_valid = 1'b0;
        ar_send(32'h0000_7000, 16'h0077, 8'd0, 3'd2, BURST_INCR);
        rd_beat(32'h0000_7000, 32'h1234_5678, 1'b1, 16'h0077, RESP_OKAY);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
